// File: rtl/noc_vc_input_buffer.sv
// Per-VC input buffer: circular flit FIFO with first-word-fall-through output,
// packet framing checks, complete-packet count and a sticky protocol-error flag.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_vc_input_buffer #(
   parameter int unsigned DATA_WIDTH    = `Noc_Data_Width,
   parameter int unsigned DEPTH         = 8,
   parameter int unsigned PKT_MAX_FLITS = 4
) (
   input  logic                    noc_clk,
   input  logic                    noc_rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_flit,
   input  logic                    in_is_header,
   input  logic                    in_is_tail,
   output logic                    in_VCready,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_flit,
   output logic                    out_is_header,
   output logic                    out_is_tail,
   output logic [$clog2(DEPTH):0]  pkt_count,
   output logic                    err_proto
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned EntW = DATA_WIDTH + 2;
   localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
   localparam logic [CntW-1:0] PktMax   = CntW'(PKT_MAX_FLITS);

   typedef enum logic {StIdle, StInPkt} state_e;

   state_e          state_q, state_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [CntW-1:0] pkt_cnt_q, pkt_cnt_d;
   logic            err_q, err_d;
   logic [EntW-1:0] mem_q [DEPTH];
   logic [EntW-1:0] head;
   logic            accept, write, pop, push_tail, pop_tail;

   always_comb begin
      in_ready  = count_q < DepthCnt;
      accept    = in_valid & in_ready;
      // Headerless flits in IDLE are consumed but never written.
      write     = accept & ((state_q == StInPkt) | in_is_header);
      out_valid = count_q != '0;
      pop       = out_valid & out_ready;
      head      = mem_q[rd_ptr_q];
      // Entry layout is {header, tail, flit}.
      push_tail = write & in_is_tail;
      pop_tail  = pop & head[DATA_WIDTH];

      out_flit      = out_valid ? head[DATA_WIDTH-1:0] : '0;
      out_is_header = out_valid & head[EntW-1];
      out_is_tail   = out_valid & head[DATA_WIDTH];
      in_VCready    = (state_q == StIdle) && ((DepthCnt - count_q) >= PktMax);
      pkt_count     = pkt_cnt_q;
      err_proto     = err_q;

      wr_ptr_d = wr_ptr_q + PtrW'(write);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);

      count_d = count_q;
      unique case ({write, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      pkt_cnt_d = pkt_cnt_q;
      unique case ({push_tail, pop_tail})
         2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
         2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
         default: pkt_cnt_d = pkt_cnt_q;
      endcase

      err_d = err_q
            | (accept & (state_q == StIdle) & ~in_is_header)
            | (write & (state_q == StInPkt) & in_is_header);

      // Any stored flit sets the state from its own tail bit.
      state_d = state_q;
      if (write) begin
         state_d = in_is_tail ? StIdle : StInPkt;
      end
   end

   always_ff @(posedge noc_clk) begin
      if (noc_rst) begin
         state_q   <= StIdle;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         pkt_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         pkt_cnt_q <= pkt_cnt_d;
         err_q     <= err_d;
      end
   end

   always_ff @(posedge noc_clk) begin
      if (write) begin
         mem_q[wr_ptr_q] <= {in_is_header, in_is_tail, in_flit};
      end
   end

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Scoreboard bench for noc_vc_input_buffer: directed stimulus queues expected
// flits, a negedge monitor compares every popped flit in order.
module tb_noc_vc_input_buffer;
   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned PKT   = 4;

   logic          noc_clk = 1'b0;
   logic          noc_rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_flit = '0;
   logic          in_is_header = 1'b0;
   logic          in_is_tail = 1'b0;
   logic          in_VCready;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_flit;
   logic          out_is_header;
   logic          out_is_tail;
   logic [3:0]    pkt_count;
   logic          err_proto;

   int            checks = 0;
   int            failures = 0;
   logic          mon_en = 1'b0;
   logic [DW+1:0] exp_q[$];

   always #5 noc_clk = ~noc_clk;

   noc_vc_input_buffer #(
      .DATA_WIDTH   (DW),
      .DEPTH        (DEPTH),
      .PKT_MAX_FLITS(PKT)
   ) dut (
      .noc_clk      (noc_clk),
      .noc_rst      (noc_rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_flit      (in_flit),
      .in_is_header (in_is_header),
      .in_is_tail   (in_is_tail),
      .in_VCready   (in_VCready),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_flit     (out_flit),
      .out_is_header(out_is_header),
      .out_is_tail  (out_is_tail),
      .pkt_count    (pkt_count),
      .err_proto    (err_proto)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge noc_clk);
      #1;
   endtask

   task automatic drive(input logic h, input logic t, input logic [DW-1:0] d, input logic stored);
      in_valid     = 1'b1;
      in_is_header = h;
      in_is_tail   = t;
      in_flit      = d;
      if (stored) exp_q.push_back({h, t, d});
   endtask

   task automatic idle_in();
      in_valid     = 1'b0;
      in_is_header = 1'b0;
      in_is_tail   = 1'b0;
      in_flit      = '0;
   endtask

   task automatic do_reset(input int cycles);
      out_ready = 1'b0;
      idle_in();
      noc_rst = 1'b1;
      for (int i = 0; i < cycles; i++) tick();
      noc_rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic drain(input string name);
      idle_in();
      out_ready = 1'b1;
      for (int i = 0; i < 40 && out_valid; i++) tick();
      check(name, 32'(out_valid), 32'd0);
      out_ready = 1'b0;
   endtask

   // Monitor: compare each popped flit against the head of the expected queue.
   initial begin
      logic [DW+1:0] e;
      forever begin
         @(negedge noc_clk);
         if (mon_en && !noc_rst) begin
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_pop: got 0x%0h, expected no output",
                           {out_is_header, out_is_tail, out_flit});
               end else begin
                  e = exp_q.pop_front();
                  check("fifo_order", 32'({out_is_header, out_is_tail, out_flit}), 32'(e));
               end
            end else if (!out_valid) begin
               check("idle_outputs_zero", 32'({out_is_header, out_is_tail, out_flit}), 32'd0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      do_reset(2);
      mon_en = 1'b1;

      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_vcready", 32'(in_VCready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_flit", 32'(out_flit), 32'd0);
      check("rst_out_hdr", 32'(out_is_header), 32'd0);
      check("rst_out_tail", 32'(out_is_tail), 32'd0);
      check("rst_pkt_count", 32'(pkt_count), 32'd0);
      check("rst_err", 32'(err_proto), 32'd0);

      // 4-flit packet held with out_ready=0.
      drive(1'b1, 1'b0, 16'hA0, 1'b1);
      check("no_bypass", 32'(out_valid), 32'd0);
      tick();
      check("fwft_valid", 32'(out_valid), 32'd1);
      check("fwft_flit", 32'(out_flit), 32'hA0);
      check("fwft_hdr", 32'(out_is_header), 32'd1);
      drive(1'b0, 1'b0, 16'hA1, 1'b1); tick();
      drive(1'b0, 1'b0, 16'hA2, 1'b1); tick();
      drive(1'b0, 1'b1, 16'hA3, 1'b1); tick();
      idle_in();
      check("pkt1_count", 32'(pkt_count), 32'd1);
      check("pkt1_vcready", 32'(in_VCready), 32'd1);
      check("pkt1_in_ready", 32'(in_ready), 32'd1);
      check("pkt1_head", 32'(out_flit), 32'hA0);

      // Fill to DEPTH, then pop with in_valid held: no push while full.
      drive(1'b1, 1'b0, 16'hB0, 1'b1); tick();
      drive(1'b0, 1'b0, 16'hB1, 1'b1); tick();
      drive(1'b0, 1'b0, 16'hB2, 1'b1); tick();
      drive(1'b0, 1'b1, 16'hB3, 1'b1); tick();
      idle_in();
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_vcready", 32'(in_VCready), 32'd0);
      check("full_pkt_count", 32'(pkt_count), 32'd2);
      drive(1'b1, 1'b1, 16'hC0, 1'b0);
      out_ready = 1'b1;
      check("full_pop_in_ready", 32'(in_ready), 32'd0);
      tick();
      out_ready = 1'b0;
      drive(1'b1, 1'b1, 16'hC0, 1'b1);
      check("after_pop_in_ready", 32'(in_ready), 32'd1);
      tick();
      idle_in();
      check("refill_in_ready", 32'(in_ready), 32'd0);
      check("refill_pkt_count", 32'(pkt_count), 32'd3);
      drain("drain1");
      check("drain1_pkt_count", 32'(pkt_count), 32'd0);
      check("drain1_vcready", 32'(in_VCready), 32'd1);

      // Single-flit packet.
      drive(1'b1, 1'b1, 16'hD0, 1'b1);
      tick();
      idle_in();
      check("single_pkt_count", 32'(pkt_count), 32'd1);
      check("single_vcready", 32'(in_VCready), 32'd1);
      check("single_tail", 32'(out_is_tail), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("single_popped_count", 32'(pkt_count), 32'd0);
      check("single_popped_valid", 32'(out_valid), 32'd0);

      // Headerless flits while IDLE are dropped and flag an error.
      check("pre_err", 32'(err_proto), 32'd0);
      drive(1'b0, 1'b0, 16'hE0, 1'b0);
      check("body_idle_in_ready", 32'(in_ready), 32'd1);
      tick();
      idle_in();
      check("body_idle_not_stored", 32'(out_valid), 32'd0);
      check("body_idle_err", 32'(err_proto), 32'd1);
      drive(1'b0, 1'b1, 16'hE1, 1'b0);
      tick();
      idle_in();
      check("tail_idle_pkt_count", 32'(pkt_count), 32'd0);
      check("tail_idle_not_stored", 32'(out_valid), 32'd0);
      tick(); tick(); tick();
      check("err_sticky", 32'(err_proto), 32'd1);

      // Streaming at occupancy 1 across several pointer wraps.
      drive(1'b1, 1'b0, 16'h100, 1'b1);
      tick();
      out_ready = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         drive(1'b0, (i == 20), DW'(32'h100 + i), 1'b1);
         tick();
         check("stream_valid", 32'(out_valid), 32'd1);
         check("stream_in_ready", 32'(in_ready), 32'd1);
      end
      idle_in();
      out_ready = 1'b0;
      check("stream_pkt_count", 32'(pkt_count), 32'd1);
      check("stream_head", 32'(out_flit), 32'h114);
      drain("drain2");
      check("stream_end_pkt_count", 32'(pkt_count), 32'd0);
      check("stream_end_vcready", 32'(in_VCready), 32'd1);

      // Reset mid-packet with 3 flits stored.
      drive(1'b1, 1'b0, 16'h200, 1'b1); tick();
      drive(1'b0, 1'b0, 16'h201, 1'b1); tick();
      drive(1'b0, 1'b0, 16'h202, 1'b1); tick();
      idle_in();
      check("midpkt_pkt_count", 32'(pkt_count), 32'd0);
      check("midpkt_vcready", 32'(in_VCready), 32'd0);
      do_reset(1);
      check("mrst_out_valid", 32'(out_valid), 32'd0);
      check("mrst_pkt_count", 32'(pkt_count), 32'd0);
      check("mrst_vcready", 32'(in_VCready), 32'd1);
      check("mrst_err", 32'(err_proto), 32'd0);
      check("mrst_in_ready", 32'(in_ready), 32'd1);

      // Header inside a packet is stored, flags an error, state follows its tail.
      drive(1'b1, 1'b0, 16'h210, 1'b1); tick();
      drive(1'b1, 1'b1, 16'h211, 1'b1); tick();
      idle_in();
      check("hdr_in_pkt_err", 32'(err_proto), 32'd1);
      check("hdr_in_pkt_vcready", 32'(in_VCready), 32'd1);
      check("hdr_in_pkt_count", 32'(pkt_count), 32'd1);
      drain("drain3");

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
